lcd_arbiter: RTL
================

LCD_ARBITER -- requirements
Module: lcd_arbiter

Interface
REQ-001 The block SHALL have parameter COUNT_MAX, default 8, giving the clock cycles per bus phase (SETUP, PULSE, HOLD).
REQ-002 The block SHALL have parameter CLEAR_WAIT, default 64, giving the extra idle cycles after the clear-display command.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester has a character pending.
REQ-006 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each: the arbiter accepts the payload this cycle.
REQ-007 The block SHALL have ports req0_row and req1_row, input, 1 bit each: display line (0 = top, 1 = bottom).
REQ-008 The block SHALL have ports req0_col and req1_col, input, 4 bits each: column 0-15.
REQ-009 The block SHALL have ports req0_char and req1_char, input, 8 bits each: character code.
REQ-010 The block SHALL have port init_done, output, 1 bit: the LCD init sequence is complete.
REQ-011 The block SHALL have port busy, output, 1 bit: the arbiter is not in IDLE.
REQ-012 The block SHALL have ports rs, rw and enable, output, 1 bit each: LCD1602 register select, read/write and enable strobe.
REQ-013 The block SHALL have port data, output, 8 bits: LCD1602 data bus.

Function
REQ-014 The block SHALL implement states INIT, INIT_WAIT, IDLE, ADDR_WR and CHAR_WR.
REQ-015 Every bus write SHALL consist of three phases of COUNT_MAX cycles each: SETUP (enable=0), PULSE (enable=1) and HOLD (enable=0), for 3*COUNT_MAX cycles total.
REQ-016 The rs and data outputs SHALL remain stable for the whole of a bus write.
REQ-017 The rw output SHALL be held at 0 at all times, since the block only writes.
REQ-018 In INIT, the block SHALL issue the commands 0x38, 0x0C, 0x06 and 0x01 in that order, each with rs=0.
REQ-019 After the 0x01 command, the block SHALL stay in INIT_WAIT for CLEAR_WAIT cycles, then set init_done=1 and enter IDLE.
REQ-020 Once set, init_done SHALL remain 1 until the next reset.
REQ-021 reqN_ready SHALL be combinational: 1 only in IDLE and only for the requester granted that cycle.
REQ-022 A payload SHALL be captured on a clock edge where reqN_valid and reqN_ready are both 1.
REQ-023 A requester SHALL hold valid and its payload stable until accepted.
REQ-024 reqN_ready SHALL be 0 in every state other than IDLE, including during init.
REQ-025 Arbitration SHALL be round-robin: with one requester valid, that requester is granted.
REQ-026 With both requesters valid, the requester that was not granted last SHALL win.
REQ-027 The last-grant register SHALL update only on acceptance.
REQ-028 After acceptance, the block SHALL enter ADDR_WR and write the address command with rs=0 and data = 0x80 | (row<<6) | col, giving 0x80-0x8F for row 0 and 0xC0-0xCF for row 1.
REQ-029 After ADDR_WR, the block SHALL enter CHAR_WR and write the captured character with rs=1, then return to IDLE.
REQ-030 A transaction SHALL take 6*COUNT_MAX cycles from acceptance to IDLE.
REQ-031 Back-to-back acceptance SHALL be possible on the first IDLE cycle after a transaction.
REQ-032 busy SHALL be 1 in every state except IDLE.
REQ-033 A col value above 15 cannot occur (4-bit field), so no wrap handling SHALL be implemented.
REQ-034 The phase counter width SHALL be sized for max(COUNT_MAX, CLEAR_WAIT).
REQ-035 The phase counter SHALL count 0 to limit-1 and then clear.

Reset
REQ-036 On reset=0, the block SHALL immediately and asynchronously drive rs=0, rw=0, enable=0, data=0x00, init_done=0 and busy=1.
REQ-037 On reset=0, the block SHALL clear the counters, set the last-grant register to 1 (so req0 wins first) and enter INIT.
REQ-038 A reset asserted mid-transaction or mid-init SHALL abort the bus write immediately (enable low) and discard the captured payload.
REQ-039 Init SHALL restart from 0x38 after reset release.

Structure
REQ-040 Package lcd_pkg SHALL hold the state encoding and the command constants CMD_FUNC_SET=0x38, CMD_DISP_ON=0x0C, CMD_ENTRY=0x06, CMD_CLEAR=0x01 and CMD_DDRAM=0x80.
REQ-041 Sub-module lcd_bus_writer SHALL implement the start/done handshake, the three-phase timer and the enable/rs/data drive, and the arbiter FSM SHALL sequence it.

Verification
REQ-042 Verification SHALL use COUNT_MAX=8 and CLEAR_WAIT=64 in all scenarios.
REQ-043 Release reset with no requests -> data = 0x38, 0x0C, 0x06, 0x01 with rs=0, each enable pulse 8 cycles wide; init_done=1 exactly 160 cycles after release.
REQ-044 After init, req0 (row=1, col=5, char=0x41) -> ready for 1 cycle; data=0xC5 rs=0, then data=0x41 rs=1; busy falls 48 cycles after acceptance.
REQ-045 req0 and req1 valid together, twice in a row -> order req0, req1, req0, req1.
REQ-046 req1 valid alone twice, then both valid -> req1, req1, then req0 granted.
REQ-047 req0_valid asserted during init -> req0_ready=0 until init_done.
REQ-048 Assert reset during the PULSE phase of CHAR_WR -> enable=0 within the same cycle; after release the 0x38 command reissues and no 0x41 write appears.

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared definitions for the LCD1602 write arbiter: state and
//               bus-phase encodings, LCD command constants and helpers that
//               build init commands and DDRAM address commands.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_INIT_WAIT = 3'd1,
    ST_IDLE      = 3'd2,
    ST_ADDR_WR   = 3'd3,
    ST_CHAR_WR   = 3'd4
  } arb_state_e;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_SETUP = 2'd1,
    PH_PULSE = 2'd2,
    PH_HOLD  = 2'd3
  } bus_phase_e;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_DDRAM    = 8'h80;

  localparam int INIT_CMDS = 4;

  // Init command issued at position idx of the power-up sequence.
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return CMD_FUNC_SET;
      3'd1:    return CMD_DISP_ON;
      3'd2:    return CMD_ENTRY;
      3'd3:    return CMD_CLEAR;
      default: return 8'h00;
    endcase
  endfunction

  // Set-DDRAM-address command: row 1 starts at DDRAM offset 0x40.
  function automatic logic [7:0] ddram_addr(input logic row, input logic [3:0] col);
    return CMD_DDRAM | {1'b0, row, 2'b00, col};
  endfunction

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_bus_writer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_bus_writer
// Description : Performs one LCD1602 bus write as SETUP / PULSE / HOLD phases
//               of COUNT_MAX cycles each. rs and data are latched at start and
//               held for the whole write.
// Ports       : clk, reset (async, active-low)
//               start_i, rs_i, data_i : request a write (sampled when free_o)
//               free_o                : a new start is accepted this cycle
//               done_o                : last cycle of the current write
//               enable_o, rs_o, data_o: registered LCD bus drive
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int COUNT_MAX = 8,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic       rs_i,
  input  logic [7:0] data_i,
  output logic       free_o,
  output logic       done_o,
  output logic       enable_o,
  output logic       rs_o,
  output logic [7:0] data_o
);

  bus_phase_e       phase_q;
  logic [CNT_W-1:0] cnt_q;
  logic             en_q;
  logic             rs_q;
  logic [7:0]       data_q;
  logic             last_w;

  assign last_w = (cnt_q == CNT_W'(COUNT_MAX - 1));
  assign done_o = (phase_q == PH_HOLD) && last_w;
  // Free on the final HOLD cycle too, so consecutive writes chain with no gap.
  assign free_o = (phase_q == PH_IDLE) || done_o;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
    end else if (free_o) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
      if (start_i) begin
        phase_q <= PH_SETUP;
        rs_q    <= rs_i;
        data_q  <= data_i;
      end else begin
        phase_q <= PH_IDLE;
      end
    end else if (last_w) begin
      cnt_q <= '0;
      if (phase_q == PH_SETUP) begin
        phase_q <= PH_PULSE;
        en_q    <= 1'b1;
      end else begin
        phase_q <= PH_HOLD;
        en_q    <= 1'b0;
      end
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign enable_o = en_q;
  assign rs_o     = rs_q;
  assign data_o   = data_q;

endmodule : lcd_bus_writer
`default_nettype wire

// File: rtl/lcd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lcd_arbiter
// Description : Initialises an LCD1602 and then arbitrates round-robin between
//               two character requesters, writing a DDRAM address command
//               followed by the character for each accepted request.
// Ports       : clk, reset (async, active-low)
//               reqN_valid/ready/row/col/char : requester N handshake+payload
//               init_done : init sequence complete (sticky until reset)
//               busy      : not in IDLE
//               rs, rw, enable, data : LCD1602 bus
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_arbiter
  import lcd_pkg::*;
#(
  parameter int COUNT_MAX  = 8,
  parameter int CLEAR_WAIT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic       req0_row,
  input  logic [3:0] req0_col,
  input  logic [7:0] req0_char,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic       req1_row,
  input  logic [3:0] req1_col,
  input  logic [7:0] req1_char,
  output logic       init_done,
  output logic       busy,
  output logic       rs,
  output logic       rw,
  output logic       enable,
  output logic [7:0] data
);

  localparam int CNT_MAX = (COUNT_MAX > CLEAR_WAIT) ? COUNT_MAX : CLEAR_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  arb_state_e       state_q;
  logic [2:0]       cmd_idx_q;
  logic [CNT_W-1:0] wait_q;
  logic             last_q;      // 1: req1 was granted last
  logic [7:0]       char_q;
  logic             init_done_q;
  logic             busy_q;

  logic       grant0_w;
  logic       grant1_w;
  logic       accept_w;
  logic       wr_free_w;
  logic       wr_done_w;
  logic       wr_start_w;
  logic       wr_rs_w;
  logic [7:0] wr_data_w;

  // A lone requester always wins; on contention the one not granted last wins.
  assign grant0_w   = req0_valid && (!req1_valid || last_q);
  assign grant1_w   = req1_valid && (!req0_valid || !last_q);
  assign req0_ready = (state_q == ST_IDLE) && grant0_w;
  assign req1_ready = (state_q == ST_IDLE) && grant1_w;
  assign accept_w   = req0_ready || req1_ready;

  // The address write starts on the acceptance edge straight from the live
  // payload; the character write chains on the final HOLD cycle of the address.
  always_comb begin
    wr_start_w = 1'b0;
    wr_rs_w    = 1'b0;
    wr_data_w  = 8'h00;
    case (state_q)
      ST_INIT: begin
        if (wr_free_w && (cmd_idx_q != 3'(INIT_CMDS))) begin
          wr_start_w = 1'b1;
          wr_data_w  = init_cmd(cmd_idx_q);
        end
      end
      ST_IDLE: begin
        if (accept_w) begin
          wr_start_w = 1'b1;
          wr_data_w  = req0_ready ? ddram_addr(req0_row, req0_col)
                                  : ddram_addr(req1_row, req1_col);
        end
      end
      ST_ADDR_WR: begin
        if (wr_done_w) begin
          wr_start_w = 1'b1;
          wr_rs_w    = 1'b1;
          wr_data_w  = char_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      cmd_idx_q   <= 3'd0;
      wait_q      <= '0;
      last_q      <= 1'b1;
      char_q      <= 8'h00;
      init_done_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: begin
          // Writer is free once at start and then at the end of each command.
          if (wr_free_w) begin
            if (cmd_idx_q != 3'(INIT_CMDS)) begin
              cmd_idx_q <= cmd_idx_q + 1'b1;
            end else begin
              state_q <= ST_INIT_WAIT;
              wait_q  <= '0;
            end
          end
        end
        ST_INIT_WAIT: begin
          if (wait_q == CNT_W'(CLEAR_WAIT - 1)) begin
            wait_q      <= '0;
            state_q     <= ST_IDLE;
            init_done_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept_w) begin
            last_q  <= req1_ready;
            char_q  <= req1_ready ? req1_char : req0_char;
            state_q <= ST_ADDR_WR;
            busy_q  <= 1'b1;
          end
        end
        ST_ADDR_WR: begin
          if (wr_done_w) state_q <= ST_CHAR_WR;
        end
        ST_CHAR_WR: begin
          if (wr_done_w) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  lcd_bus_writer #(
    .COUNT_MAX (COUNT_MAX),
    .CNT_W     (CNT_W)
  ) u_writer (
    .clk      (clk),
    .reset    (reset),
    .start_i  (wr_start_w),
    .rs_i     (wr_rs_w),
    .data_i   (wr_data_w),
    .free_o   (wr_free_w),
    .done_o   (wr_done_w),
    .enable_o (enable),
    .rs_o     (rs),
    .data_o   (data)
  );

  assign rw        = 1'b0;
  assign init_done = init_done_q;
  assign busy      = busy_q;

endmodule : lcd_arbiter
`default_nettype wire
